// File: rtl/teclado_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package teclado_pkg;

  localparam int unsigned KEY_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DEB_PRESS,
    EMIT,
    WAIT_REL,
    DEB_REL
  } estado_t;

  localparam logic [3:0] COL_0 = 4'b0001;
  localparam logic [3:0] COL_1 = 4'b0010;
  localparam logic [3:0] COL_2 = 4'b0100;
  localparam logic [3:0] COL_3 = 4'b1000;

  function automatic logic [3:0] sig_columna(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

  function automatic logic [1:0] indice(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = i[1:0];
    end
    return idx;
  endfunction

  function automatic logic es_onehot(input logic [3:0] v);
    return (v != '0) && ((v & (v - 4'd1)) == '0);
  endfunction

endpackage

// File: rtl/contador_rebote.sv
// Saturating up-counter with clear/load/enable and a terminal-count flag.
module contador_rebote #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_val,
  output logic             tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] cuenta;

  assign tc = (cuenta == TC_VAL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cuenta <= '0;
    end else if (clear) begin
      cuenta <= '0;
    end else if (load) begin
      cuenta <= load_val;
    end else if (en && !tc) begin
      cuenta <= cuenta + WIDTH'(1);
    end
  end

endmodule

// File: rtl/control_barrido_teclado.sv
// Keypad column scanner with press/release debounce and valid/ready key output.
module control_barrido_teclado
  import teclado_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEB_CYCLES = 20000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       filas,
  output logic [3:0]       columnas,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             key_error
);

  localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
  localparam int unsigned DEB_W   = $clog2(DEB_CYCLES);

  estado_t    estado;
  logic [3:0] fila_lat;
  logic       armado;

  logic dwell_en, dwell_clr, dwell_tc;
  logic deb_match, deb_en, deb_clr, deb_tc;

  // Terminal counts are N-1 so the Nth qualifying cycle is the one that acts.
  always_comb begin
    dwell_en  = (estado == SCAN);
    dwell_clr = !enable || (estado != SCAN) || dwell_tc;
    deb_match = (estado == DEB_PRESS) ? (filas == fila_lat) : (filas == '0);
    deb_en    = ((estado == DEB_PRESS) || (estado == DEB_REL)) && deb_match;
    deb_clr   = !enable || !deb_en || deb_tc;
  end

  contador_rebote #(
    .WIDTH   (DWELL_W),
    .TERMINAL(SCAN_DIV - 1)
  ) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .clear   (dwell_clr),
    .load    (1'b0),
    .en      (dwell_en),
    .load_val('0),
    .tc      (dwell_tc)
  );

  contador_rebote #(
    .WIDTH   (DEB_W),
    .TERMINAL(DEB_CYCLES - 1)
  ) u_deb (
    .clk     (clk),
    .reset   (reset),
    .clear   (deb_clr),
    .load    (1'b0),
    .en      (deb_en),
    .load_val('0),
    .tc      (deb_tc)
  );

  // armado delays the first scan by one edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado    <= IDLE;
      columnas  <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_error <= 1'b0;
      fila_lat  <= '0;
      armado    <= 1'b0;
    end else begin
      armado    <= 1'b1;
      key_error <= 1'b0;
      if (!enable) begin
        estado    <= IDLE;
        columnas  <= '0;
        key_valid <= 1'b0;
      end else begin
        case (estado)
          IDLE: begin
            if (armado) begin
              estado   <= SCAN;
              columnas <= COL_0;
            end
          end
          SCAN: begin
            if (dwell_tc) begin
              if (filas != '0) begin
                fila_lat <= filas;
                estado   <= DEB_PRESS;
              end else begin
                columnas <= sig_columna(columnas);
              end
            end
          end
          DEB_PRESS: begin
            if (filas != fila_lat) begin
              estado   <= SCAN;
              columnas <= sig_columna(columnas);
            end else if (deb_tc) begin
              if (es_onehot(fila_lat)) begin
                key_code  <= {indice(columnas), indice(fila_lat)};
                key_valid <= 1'b1;
                estado    <= EMIT;
              end else begin
                key_error <= 1'b1;
                estado    <= WAIT_REL;
              end
            end
          end
          EMIT: begin
            if (key_ready) begin
              key_valid <= 1'b0;
              estado    <= WAIT_REL;
            end
          end
          WAIT_REL: begin
            if (filas == '0) estado <= DEB_REL;
          end
          DEB_REL: begin
            if (filas != '0) begin
              estado <= WAIT_REL;
            end else if (deb_tc) begin
              estado   <= SCAN;
              columnas <= sig_columna(columnas);
            end
          end
          default: begin
            estado    <= IDLE;
            columnas  <= '0;
            key_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/control_barrido_teclado.md
CONTROL_BARRIDO_TECLADO -- requirements
Module: control_barrido_teclado

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 1000: clk cycles each column is driven before advancing (legal range 2..65535).
REQ-002 The block SHALL have parameter DEB_CYCLES, default 20000: consecutive stable cycles required to accept a press or a release (legal range 2..2^20-1).
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port enable, input, 1 bit: 1 = scanning allowed; 0 = freeze in IDLE.
REQ-006 The block SHALL have port filas, input, 4 bits: keypad row sense lines, active-high, already synchronized by the caller.
REQ-007 The block SHALL have port columnas, output, 4 bits: one-hot column drive, or 0 when idle.
REQ-008 The block SHALL have port key_code, output, 4 bits: accepted key as {col[1:0], row[1:0]}.
REQ-009 The block SHALL have port key_valid, output, 1 bit: key_code holds an unconsumed key.
REQ-010 The block SHALL have port key_ready, input, 1 bit: the consumer accepts key_code on any cycle where key_valid=1 and key_ready=1.
REQ-011 The block SHALL have port key_error, output, 1 bit: one-cycle pulse when a press is rejected.

Function
REQ-012 The block SHALL implement the states IDLE, SCAN, DEB_PRESS, EMIT, WAIT_REL and DEB_REL.
REQ-013 IDLE: columnas=0; the block SHALL go to SCAN with columnas=0001 on the first cycle enable=1.
REQ-014 SCAN: each column SHALL be held for exactly SCAN_DIV cycles, then advance 0001->0010->0100->1000->0001 (wrap-around).
REQ-015 SCAN: when filas!=0 in the last cycle of a column dwell, the block SHALL latch the column and the row pattern and go to DEB_PRESS, holding columnas.
REQ-016 DEB_PRESS: a counter SHALL count cycles where filas equals the latched pattern; any mismatch SHALL return to SCAN at the next column without emitting.
REQ-017 DEB_PRESS: when the count reaches DEB_CYCLES and the pattern is one-hot, the block SHALL load key_code and go to EMIT.
REQ-018 DEB_PRESS: when the count reaches DEB_CYCLES and the pattern is multi-hot (two or more rows), the block SHALL pulse key_error for one cycle, load nothing and go to WAIT_REL.
REQ-019 EMIT: key_valid SHALL be 1, and key_code SHALL remain stable until the handshake.
REQ-020 EMIT: on key_valid and key_ready, key_valid SHALL drop on the next cycle and the block SHALL go to WAIT_REL.
REQ-021 EMIT: key_ready asserted before key_valid SHALL have no effect; there is no combinational path from key_ready to key_valid.
REQ-022 WAIT_REL: columnas SHALL stay on the latched column; filas==0 SHALL start DEB_REL.
REQ-023 DEB_REL: DEB_CYCLES consecutive cycles with filas==0 SHALL resume SCAN at the column after the latched one; any filas!=0 SHALL return to WAIT_REL and clear the counter.
REQ-024 Exactly one key_valid transaction SHALL occur per physical press, however long the key is held.
REQ-025 enable=0 in any state SHALL go to IDLE on the next cycle, clearing key_valid and all counters; an unconsumed key is discarded.
REQ-026 Latency from a stable one-hot press to key_valid SHALL be at most 4*SCAN_DIV + DEB_CYCLES + 2 cycles.
REQ-027 Counters SHALL saturate and never wrap; SCAN_DIV and DEB_CYCLES comparisons SHALL be equality on counters sized by $clog2.

Reset
REQ-028 While reset=0, the block SHALL set state=IDLE, columnas=0, key_code=0, key_valid=0, key_error=0, and all counters to 0, asynchronously.
REQ-029 Reset release SHALL be sampled synchronously; the first SCAN cycle SHALL be no earlier than the second clk edge after release with enable=1.
REQ-030 Reset asserted mid-EMIT SHALL drop key_valid immediately, with no handshake.

Structure
REQ-031 The state enumeration, the key_code width (4) and the column one-hot constants SHALL live in teclado_pkg.
REQ-032 A single sub-module, contador_rebote (load/clear/enable saturating counter with terminal-count flag), SHALL be used for both dwell and debounce counting.
REQ-033 All outputs SHALL be registered.

Verification (SCAN_DIV=4, DEB_CYCLES=8)
REQ-034 The bench SHALL hold filas=0 with enable=1 for 40 cycles and check that columnas cycles 0001,0010,0100,1000 with 4 cycles each, that no key_valid occurs and that key_error stays 0.
REQ-035 The bench SHALL press row 2 while columnas=0100 for 30 cycles with key_ready=1 and check exactly one key_valid with key_code=4'b1010, then resume scanning at column 1000 after 8 release cycles.
REQ-036 The bench SHALL drive filas=0010 for 3 cycles then 0 (a bounce) and check no key_valid and that the scan resumes.
REQ-037 The bench SHALL drive filas=0101 stable on column 0001 and check one key_error pulse, no key_valid, and a return to scanning after release.
REQ-038 The bench SHALL hold key_ready=0 for 50 cycles after key_valid and check that key_valid and key_code are stable, then raise key_ready for 1 cycle and check that key_valid clears on the next cycle.
REQ-039 The bench SHALL assert reset=0 during EMIT and during DEB_PRESS and check that all outputs are 0 within the same cycle and that scanning restarts at 0001 after release.
